// File: rtl/vga_pkg.sv
// Timing defaults for 640x480@60, pixel type and controller state encoding
// shared by the VGA stream source and its raster counter.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int HS_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int HS_END   = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF - 1;
  localparam int VS_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int VS_END   = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF - 1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic in_window(input logic [CNT_W-1:0] val,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Raster position counters (column, line) with wrap and a last-pixel flag;
// parked at the origin whenever run_i is low.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int H_TOTAL_P = H_TOTAL,
  parameter int V_TOTAL_P = V_TOTAL
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             run_i,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL_P - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL_P - 1);

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             h_last, v_last;

  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!run_i) begin
      h_d = '0;
      v_d = '0;
    end else if (h_last) begin
      h_d = '0;
      v_d = v_last ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt_o = h_q;
  assign v_cnt_o = v_q;
  assign last_o  = h_last && v_last;

endmodule

// File: rtl/vga_stream_source.sv
// VGA raster source: counts the raster, requests pixels from a frame source
// one stage ahead and emits DE/HSYNC/VSYNC/SOF aligned with the returned pixel.
module vga_stream_source
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIX_W    = 24
) (
  input  logic             I_PCLK,
  input  logic             I_RST_N,
  input  logic             I_EN,
  input  logic [PIX_W-1:0] I_PIX_DATA,
  output logic             O_PIX_REQ,
  output logic [CNT_W-1:0] O_REQ_X,
  output logic [CNT_W-1:0] O_REQ_Y,
  output logic [PIX_W-1:0] O_PIX_DATA,
  output logic             O_DE,
  output logic             O_HSYNC,
  output logic             O_VSYNC,
  output logic             O_SOF,
  output logic             O_BUSY
);

  // state | meaning
  // IDLE  | counters parked at (0,0), syncs inactive, no requests
  // RUN   | raster running; I_EN is only looked at on the last count of a frame

  localparam int H_TOTAL_C = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL_C = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  state_e           state_q, state_d;
  logic             run;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             frame_last;

  logic             req_d, req_q;
  logic [CNT_W-1:0] req_x_d, req_x_q;
  logic [CNT_W-1:0] req_y_d, req_y_q;
  logic             hs1_d, hs1_q;
  logic             vs1_d, vs1_q;
  logic             sof1_d, sof1_q;

  logic             de_q, hs_q, vs_q, sof_q;
  logic [PIX_W-1:0] pix_d, pix_q;

  assign run = (state_q == RUN);

  vga_timing_counter #(
    .H_TOTAL_P(H_TOTAL_C),
    .V_TOTAL_P(V_TOTAL_C)
  ) u_cnt (
    .clk_i  (I_PCLK),
    .rst_n_i(I_RST_N),
    .run_i  (run),
    .h_cnt_o(h_cnt),
    .v_cnt_o(v_cnt),
    .last_o (frame_last)
  );

  always_ff @(posedge I_PCLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (I_EN) state_d = RUN;
      RUN:     if (frame_last && !I_EN) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage 1: request and sync copies decoded straight from the counters.
  always_comb begin
    req_d   = run && (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    req_x_d = req_d ? h_cnt : req_x_q;
    req_y_d = req_d ? v_cnt : req_y_q;
    hs1_d   = (run && in_window(h_cnt, HS_START_C, HS_END_C)) ? SYNC_POL : ~SYNC_POL;
    vs1_d   = (run && in_window(v_cnt, VS_START_C, VS_END_C)) ? SYNC_POL : ~SYNC_POL;
    sof1_d  = req_d && (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge I_PCLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      req_q   <= 1'b0;
      req_x_q <= '0;
      req_y_q <= '0;
      hs1_q   <= ~SYNC_POL;
      vs1_q   <= ~SYNC_POL;
      sof1_q  <= 1'b0;
    end else begin
      req_q   <= req_d;
      req_x_q <= req_x_d;
      req_y_q <= req_y_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      sof1_q  <= sof1_d;
    end
  end

  // Stage 2: the source answers during the request cycle, so the pixel is
  // captured on the same edge that turns the request into DE.
  assign pix_d = req_q ? I_PIX_DATA : '0;

  always_ff @(posedge I_PCLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      de_q  <= 1'b0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      sof_q <= 1'b0;
      pix_q <= '0;
    end else begin
      de_q  <= req_q;
      hs_q  <= hs1_q;
      vs_q  <= vs1_q;
      sof_q <= sof1_q;
      pix_q <= pix_d;
    end
  end

  assign O_PIX_REQ  = req_q;
  assign O_REQ_X    = req_x_q;
  assign O_REQ_Y    = req_y_q;
  assign O_PIX_DATA = pix_q;
  assign O_DE       = de_q;
  assign O_HSYNC    = hs_q;
  assign O_VSYNC    = vs_q;
  assign O_SOF      = sof_q;
  assign O_BUSY     = run;

endmodule
